msx_mouse_port: RTL
===================

// Module: msx_mouse_port
// PURPOSE
// Parametrised MSX general-purpose-port encoder between the MiST user_io (PS/2 mouse
// packets, 6-bit joystick) and one emsx_top joystick port (pJoyA/pJoyB + pStra/pStrb).
// Multiplexes joystick and MSX mouse protocol with forced/auto mode selection.
// Accumulates mouse deltas between host reads with saturation, instead of overwriting them.
// One instance per MSX port; the top level instantiates two.
// PARAMETERS
// ACC_W        12      signed width of X/Y delta accumulators (>=9)
// TIMEOUT      100000  clk_sys cycles without strobe edge before nibble sequence restarts
// SYNC_STAGES  2       flip-flops on stra before edge detect (0 = none, same-domain)
// INVERT_X     1       1: negate PS/2 X so MSX left-move is positive
// JOY_STR_GATE 1       1: joystick pins driven only while stra==0
// PORTS
// clk_sys      in   1   system clock (21.48 MHz)
// reset        in   1   asynchronous, active-high reset
// mode_sel     in   2   00 auto, 01 force joystick, 10 force mouse, 11 = 00
// joy_n        in   6   joystick, active-low {btnB,btnA,right,left,down,up}
// mouse_strobe in   1   1-cycle pulse: mouse_x/y/btn valid
// mouse_x      in   9   PS/2 X delta, two's complement
// mouse_y      in   9   PS/2 Y delta, two's complement
// mouse_btn    in   2   {right,left}, active-high
// stra         in   1   MSX port strobe (pin 8) from emsx_top
// pin_low      out  6   1 = pull that port pin low; 0 = release (top converts to 1'bZ)
// mouse_active out  1   1 = port currently in mouse protocol
// acc_sat      out  1   sticky: an accumulator clipped since last reset
// BEHAVIOUR
// - Reset: pin_low=0, mouse_active=0, acc_sat=0, accumulators=0, nibble state=0,
//   timeout counter=0, sync chain=0.
// - Mode: 01 -> mouse_active=0; 10 -> mouse_active=1; auto: set by mouse_strobe, cleared
//   by any joy_n bit ==0 in a cycle without mouse_strobe (strobe wins if simultaneous).
// - Joystick path (mouse_active=0): pin_low[i] = ~joy_n[i] & (~stra_s | ~JOY_STR_GATE).
//   Combinational from joy_n; stra_s = synchronised stra.
// - Accumulate: on mouse_strobe, acc_x += (INVERT_X ? -mouse_x : mouse_x) and acc_y += mouse_y,
//   both sign-extended. Results clip to +/-(2^(ACC_W-1)-1); any clip sets acc_sat.
// - Strobe edge: edge = stra_s ^ stra_d; visible at pin_low SYNC_STAGES+1 cycles after stra changes.
// - Nibble FSM (only while mouse_active), S0..S3, advances one state per edge, S3 wraps to S0:
//   S0 edge: snapshot sx=sat8(acc_x), sy=sat8(acc_y) (clip to -128..127); acc -= snapshot;
//            output sx[7:4]. Same-cycle mouse_strobe delta added after the subtraction.
//   S1 edge: output sx[3:0]; S2 edge: sy[7:4]; S3 edge: sy[3:0].
//   pin_low[3:0] = ~nibble (pin released for a 1 bit); pin_low[5:4] = mouse_btn.
// - Timeout: counter loads TIMEOUT on every edge and decrements to 0. Reaching 1 -> state=S0.
//   pin_low[3:0] unchanged. Residual motion stays in the accumulators (never lost).
// - Leaving mouse mode: state=S0, pin_low[3:0]=0. Accumulators cleared.
// - Reset mid-read: everything returns to reset values immediately (async).
// - mode_sel change takes effect the next cycle. No glitch on pin_low beyond one cycle.
// TESTING
// 1 reset asserted mid-sequence in S2 -> pin_low==0, state S0, acc 0 next cycle
// 2 mode 00, strobe x=-5 (0x1FB), y=+3, then 4 stra toggles ->
//   nibbles 0x0,0x5,0x0,0x3; pin_low[3:0] = ~nibble each time
// 3 ten strobes x=-100 each before read -> sx=0x7F, residual acc_x=873, acc_sat stays 0;
//   ACC_W=10 variant -> acc_sat=1
// 4 toggle stra twice, wait TIMEOUT+2 cycles, toggle -> X high nibble reissued from new snapshot
// 5 mode 00 in mouse, joy_n=6'b111110 with no strobe -> mouse_active=0;
//   stra=0 -> pin_low=6'b000001, stra=1 -> 0
// 6 mouse_strobe coincident with S0 edge -> snapshot excludes new delta; delta appears next read

Source files
------------

// File: rtl/msx_mouse_port.sv
// msx_mouse_port: MSX general-purpose-port encoder for one port. It muxes a
//   6-bit joystick and the MSX nibble-serial mouse protocol, and accumulates
//   PS/2 mouse deltas between host reads, saturating instead of overwriting.
// Latency: the joystick path is combinational from i_joy_n. A mouse nibble
//   appears on o_pin_low SYNC_STAGES+1 cycles after i_stra changes.
// Backpressure: none. Motion that is not yet read stays in the accumulators,
//   which clip at +/-(2^(ACC_W-1)-1) and set the sticky o_acc_sat.
//
// Ports:
//   i_clk_sys       system clock
//   i_reset         asynchronous active-high reset
//   i_mode_sel      00/11 auto, 01 force joystick, 10 force mouse
//   i_joy_n         joystick {btnB,btnA,right,left,down,up}, active-low
//   i_mouse_strobe  1-cycle pulse, i_mouse_x/y/btn valid
//   i_mouse_x/y     PS/2 deltas, 9-bit two's complement
//   i_mouse_btn     {right,left}, active-high
//   i_stra          MSX port strobe (pin 8)
//   o_pin_low       1 = pull port pin low, 0 = release
//   o_mouse_active  port is in mouse protocol
//   o_acc_sat       sticky: an accumulator clipped since reset
module msx_mouse_port #(
  parameter int ACC_W        = 12,
  parameter int TIMEOUT      = 100000,
  parameter int SYNC_STAGES  = 2,
  parameter int INVERT_X     = 1,
  parameter int JOY_STR_GATE = 1
) (
  input  logic       i_clk_sys,
  input  logic       i_reset,
  input  logic [1:0] i_mode_sel,
  input  logic [5:0] i_joy_n,
  input  logic       i_mouse_strobe,
  input  logic [8:0] i_mouse_x,
  input  logic [8:0] i_mouse_y,
  input  logic [1:0] i_mouse_btn,
  input  logic       i_stra,
  output logic [5:0] o_pin_low,
  output logic       o_mouse_active,
  output logic       o_acc_sat
);

  // Two guard bits let acc - snapshot + delta be computed without wrap.
  localparam int WW = ACC_W + 2;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [WW-1:0]    LIM  = WW'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] P127 = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] N128 = ACC_W'(-128);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_mouse_active, w_active_nxt;
  logic                    r_stra_d, w_stra_s, w_edge, w_take;
  logic [3:0]              r_pin_nib, w_pin_nib_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [7:0]              r_sx, r_sy, w_sx, w_sy;
  logic signed [ACC_W-1:0] r_acc_x, r_acc_y, w_acc_x_nxt, w_acc_y_nxt;
  logic                    r_acc_sat, w_clip;
  logic signed [WW-1:0]    w_dx, w_dy, w_sum_x, w_sum_y;
  logic                    w_joy_gate;

  function automatic logic [7:0] f_sat8(input logic signed [ACC_W-1:0] a);
    if (a > P127)      f_sat8 = 8'h7F;
    else if (a < N128) f_sat8 = 8'h80;
    else               f_sat8 = a[7:0];
  endfunction

  function automatic logic signed [WW-1:0] f_ext9(input logic [8:0] v);
    f_ext9 = {{(WW-9){v[8]}}, v};
  endfunction

  function automatic logic signed [WW-1:0] f_ext8(input logic [7:0] v);
    f_ext8 = {{(WW-8){v[7]}}, v};
  endfunction

  function automatic logic signed [WW-1:0] f_extacc(input logic signed [ACC_W-1:0] v);
    f_extacc = {{2{v[ACC_W-1]}}, v};
  endfunction

  function automatic logic signed [WW-1:0] f_clip(input logic signed [WW-1:0] v);
    if (v > LIM)       f_clip = LIM;
    else if (v < -LIM) f_clip = -LIM;
    else               f_clip = v;
  endfunction

  // Strobe synchroniser; SYNC_STAGES==0 means i_stra is already in this domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_stra_s = i_stra;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_stra;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_stra_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_edge = w_stra_s ^ r_stra_d;

  // Mode: in auto, a mouse packet claims the port and any pressed joystick
  // bit releases it; the packet wins when both happen in the same cycle.
  always_comb begin
    w_active_nxt = r_mouse_active;
    case (i_mode_sel)
      2'b01:   w_active_nxt = 1'b0;
      2'b10:   w_active_nxt = 1'b1;
      default: begin
        if (i_mouse_strobe)          w_active_nxt = 1'b1;
        else if (i_joy_n != 6'h3F)   w_active_nxt = 1'b0;
      end
    endcase
  end

  // Accumulator datapath. On the S0 edge the snapshot is removed first, so a
  // delta arriving in that same cycle lands in the next read.
  always_comb begin
    w_sx    = f_sat8(r_acc_x);
    w_sy    = f_sat8(r_acc_y);
    w_take  = r_mouse_active && w_edge && (r_state == S0);
    w_dx    = (INVERT_X != 0) ? -f_ext9(i_mouse_x) : f_ext9(i_mouse_x);
    w_dy    = f_ext9(i_mouse_y);
    w_sum_x = f_extacc(r_acc_x);
    w_sum_y = f_extacc(r_acc_y);
    if (w_take) begin
      w_sum_x = w_sum_x - f_ext8(w_sx);
      w_sum_y = w_sum_y - f_ext8(w_sy);
    end
    if (i_mouse_strobe) begin
      w_sum_x = w_sum_x + w_dx;
      w_sum_y = w_sum_y + w_dy;
    end
    w_clip      = (w_sum_x > LIM) || (w_sum_x < -LIM) || (w_sum_y > LIM) || (w_sum_y < -LIM);
    w_acc_x_nxt = ACC_W'(f_clip(w_sum_x));
    w_acc_y_nxt = ACC_W'(f_clip(w_sum_y));
  end

  // Nibble sequencer: one state per strobe edge; the watchdog returns it to
  // S0 when the host abandons a read, leaving pins and accumulators alone.
  always_comb begin
    w_state_nxt   = r_state;
    w_pin_nib_nxt = r_pin_nib;
    w_cnt_nxt     = r_cnt;
    if (r_mouse_active && w_edge) begin
      w_cnt_nxt = CW'(TIMEOUT);
      case (r_state)
        S0: begin w_state_nxt = S1; w_pin_nib_nxt = ~w_sx[7:4]; end
        S1: begin w_state_nxt = S2; w_pin_nib_nxt = ~r_sx[3:0]; end
        S2: begin w_state_nxt = S3; w_pin_nib_nxt = ~r_sy[7:4]; end
        default: begin w_state_nxt = S0; w_pin_nib_nxt = ~r_sy[3:0]; end
      endcase
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CW'(1);
      if (r_cnt == CW'(1)) w_state_nxt = S0;
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S0;
      r_mouse_active <= 1'b0;
      r_stra_d       <= 1'b0;
      r_pin_nib      <= '0;
      r_cnt          <= '0;
      r_sx           <= '0;
      r_sy           <= '0;
      r_acc_x        <= '0;
      r_acc_y        <= '0;
      r_acc_sat      <= 1'b0;
    end else begin
      r_mouse_active <= w_active_nxt;
      r_stra_d       <= w_stra_s;
      if (!w_active_nxt) begin
        // Leaving (or staying out of) mouse mode discards pending motion.
        r_state   <= S0;
        r_pin_nib <= '0;
        r_cnt     <= '0;
        r_acc_x   <= '0;
        r_acc_y   <= '0;
      end else begin
        r_state   <= w_state_nxt;
        r_pin_nib <= w_pin_nib_nxt;
        r_cnt     <= w_cnt_nxt;
        r_acc_x   <= w_acc_x_nxt;
        r_acc_y   <= w_acc_y_nxt;
        if (w_clip) r_acc_sat <= 1'b1;
        if (w_take) begin
          r_sx <= w_sx;
          r_sy <= w_sy;
        end
      end
    end
  end

  assign w_joy_gate     = (JOY_STR_GATE != 0) ? ~w_stra_s : 1'b1;
  assign o_pin_low      = r_mouse_active ? {i_mouse_btn, r_pin_nib}
                                         : (~i_joy_n & {6{w_joy_gate}});
  assign o_mouse_active = r_mouse_active;
  assign o_acc_sat      = r_acc_sat;

endmodule
